// File: rtl/serial_to_parallel_collect.sv
// Collects handshaked N-bit words into a Length-deep register array and holds it until the next start.
// Define SERIAL_TO_PARALLEL_COLLECT_ZERO_PAD_EN to clear every slot on each accepted start.

module serial_to_parallel_collect_checker #(
  parameter int Length = 16,
  localparam int CW = $clog2(Length + 1)
) (
  input logic          clk,
  input logic          rst,
  input logic          assert_on,
  input logic [CW-1:0] fill_count,
  input logic          valid,
  input logic          ready,
  input logic          in_fill,
  input logic          write_en
);

  localparam logic [CW-1:0] LEN_W = CW'(Length);

  a_count_bound: assert property (@(posedge clk) disable iff (rst || !assert_on)
    fill_count <= LEN_W)
    else $error("serial_to_parallel_collect: fill_count %0d beyond Length", fill_count);

  a_valid_known: assert property (@(posedge clk) disable iff (rst || !assert_on)
    ready |-> !$isunknown(valid))
    else $error("serial_to_parallel_collect: valid_i unknown while ready_o=1");

  a_write_in_fill: assert property (@(posedge clk) disable iff (rst || !assert_on)
    write_en |-> in_fill)
    else $error("serial_to_parallel_collect: store write outside FILL");

endmodule

module serial_to_parallel_collect #(
  parameter int N      = 8,
  parameter int Length = 16,
  localparam int CW = $clog2(Length + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] count_i,
  input  logic          abort_i,
  input  logic [N-1:0]  data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [N-1:0]  store_o [Length-1:0],
  output logic [CW-1:0] fill_count_o,
  output logic          full_o,
  input  logic          assert_on_i
);

  localparam int IW = (Length > 1) ? $clog2(Length) : 1;
  localparam logic [CW-1:0] LEN_W = CW'(Length);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] target;
  logic [CW-1:0] count_inc;
  logic          load_target;
  logic          clear_count;
  logic          write_en;

  // A zero or oversized request means "fill the whole array".
  function automatic logic [CW-1:0] clamp_target(input logic [CW-1:0] req);
    if ((req == {CW{1'b0}}) || (req > LEN_W)) begin
      clamp_target = LEN_W;
    end else begin
      clamp_target = req;
    end
  endfunction

  assign count_inc = fill_count_o + CW'(1'b1);

  // Next-state and control decode; abort takes priority over start.
  always_comb begin
    state_next  = state;
    load_target = 1'b0;
    clear_count = 1'b0;
    write_en    = 1'b0;
    if (abort_i) begin
      state_next  = IDLE;
      clear_count = 1'b1;
    end else begin
      case (state)
        IDLE, FULL: begin
          if (start_i) begin
            state_next  = FILL;
            load_target = 1'b1;
            clear_count = 1'b1;
          end else begin
            state_next = state;
          end
        end
        FILL: begin
          if (valid_i) begin
            write_en = 1'b1;
            if (count_inc == target) begin
              state_next = FULL;
            end else begin
              state_next = FILL;
            end
          end else begin
            state_next = FILL;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register with handshake flags decoded from the next state only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
      full_o  <= 1'b0;
    end else begin
      state   <= state_next;
      ready_o <= (state_next == FILL);
      full_o  <= (state_next == FULL);
    end
  end

  // Target latch and accepted-word counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target       <= {CW{1'b0}};
      fill_count_o <= {CW{1'b0}};
    end else begin
      if (load_target) begin
        target <= clamp_target(count_i);
      end
      if (clear_count) begin
        fill_count_o <= {CW{1'b0}};
      end else if (write_en) begin
        fill_count_o <= count_inc;
      end
    end
  end

  // Parallel store; slots beyond the target are only touched by the optional clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Length; i++) begin
        store_o[i] <= {N{1'b0}};
      end
    end else begin
`ifdef SERIAL_TO_PARALLEL_COLLECT_ZERO_PAD_EN
      if (load_target) begin
        for (int i = 0; i < Length; i++) begin
          store_o[i] <= {N{1'b0}};
        end
      end else if (write_en) begin
        store_o[fill_count_o[IW-1:0]] <= data_i;
      end
`else
      if (write_en) begin
        store_o[fill_count_o[IW-1:0]] <= data_i;
      end
`endif
    end
  end

  serial_to_parallel_collect_checker #(
    .Length(Length)
  ) u_checker (
    .clk        (clk_i),
    .rst        (rst_i),
    .assert_on  (assert_on_i),
    .fill_count (fill_count_o),
    .valid      (valid_i),
    .ready      (ready_o),
    .in_fill    (state == FILL),
    .write_en   (write_en)
  );

endmodule

// File: tb/tb_serial_to_parallel_collect.sv
// Directed plus randomized bench for serial_to_parallel_collect (N=8, Length=4) against a behavioural model.
module tb_serial_to_parallel_collect;

  localparam int N   = 8;
  localparam int LEN = 4;
  localparam int CW  = $clog2(LEN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] count;
  logic          abort;
  logic [N-1:0]  data;
  logic          valid;
  logic          ready;
  logic [N-1:0]  store [LEN-1:0];
  logic [CW-1:0] fill_count;
  logic          full;
  logic          assert_on;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] m_store [LEN-1:0];
  int           m_fill;
  int           m_target;
  bit           m_collecting;
  bit           m_done;
  bit           zero_pad;

  serial_to_parallel_collect #(.N(N), .Length(LEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .count_i      (count),
    .abort_i      (abort),
    .data_i       (data),
    .valid_i      (valid),
    .ready_o      (ready),
    .store_o      (store),
    .fill_count_o (fill_count),
    .full_o       (full),
    .assert_on_i  (assert_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check($sformatf("%s.ready", ctx), 32'(ready), 32'(m_collecting));
    check($sformatf("%s.full", ctx), 32'(full), 32'(m_done));
    check($sformatf("%s.fill", ctx), 32'(fill_count), 32'(m_fill));
    for (int i = 0; i < LEN; i++) begin
      check($sformatf("%s.store%0d", ctx, i), 32'(store[i]), 32'(m_store[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LEN; i++) m_store[i] = '0;
    m_fill       = 0;
    m_target     = 0;
    m_collecting = 1'b0;
    m_done       = 1'b0;
  endtask

  // What one clock edge does to the collection, from the block's behavioural rules.
  task automatic model_step(input bit s, input int c, input bit a, input bit v, input logic [N-1:0] d);
    int tgt;
    tgt = (c == 0 || c > LEN) ? LEN : c;
    if (a) begin
      m_collecting = 1'b0;
      m_done       = 1'b0;
      m_fill       = 0;
    end else if (m_collecting) begin
      if (v) begin
        m_store[m_fill] = d;
        m_fill++;
        if (m_fill == m_target) begin
          m_collecting = 1'b0;
          m_done       = 1'b1;
        end
      end
    end else if (s) begin
      m_target     = tgt;
      m_fill       = 0;
      m_collecting = 1'b1;
      m_done       = 1'b0;
      if (zero_pad) begin
        for (int i = 0; i < LEN; i++) m_store[i] = '0;
      end
    end
  endtask

  task automatic cycle(input bit s, input int c, input bit a, input bit v, input logic [N-1:0] d,
                       input string ctx);
    start = s;
    count = CW'(c);
    abort = a;
    valid = v;
    data  = d;
    @(posedge clk);
    model_step(s, c, a, v, d);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [N-1:0] words [LEN];
    zero_pad = 1'b0;
`ifdef SERIAL_TO_PARALLEL_COLLECT_ZERO_PAD_EN
    zero_pad = 1'b1;
`endif
    rst = 1'b1; start = 1'b0; count = '0; abort = 1'b0; data = '0; valid = 1'b0; assert_on = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    #12 rst = 1'b0;
    cycle(0, 0, 0, 0, 8'h00, "idle");

    // Full batch of four back-to-back words.
    cycle(1, 4, 0, 0, 8'h00, "start4");
    check("start4.ready_const", 32'(ready), 32'd1);
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < LEN; i++) cycle(0, 0, 0, 1, words[i], "batch4");
    check("batch4.full_const", 32'(full), 32'd1);
    check("batch4.ready_const", 32'(ready), 32'd0);
    check("batch4.slot0_const", 32'(store[0]), 32'h11);
    check("batch4.slot3_const", 32'(store[3]), 32'h44);

    // Three words with a gappy valid.
    cycle(1, 3, 0, 0, 8'h00, "start3");
    cycle(0, 0, 0, 1, 8'h55, "gap3");
    cycle(0, 0, 0, 0, 8'hE0, "gap3");
    cycle(0, 0, 0, 1, 8'h66, "gap3");
    cycle(0, 0, 0, 0, 8'hE1, "gap3");
    cycle(0, 0, 0, 1, 8'h77, "gap3");
    check("gap3.fill_const", 32'(fill_count), 32'd3);
    check("gap3.full_const", 32'(full), 32'd1);
    check("gap3.slot3_const", 32'(store[3]), zero_pad ? 32'h00 : 32'h44);

    // Clamp: 0 and 7 both mean Length.
    cycle(1, 0, 0, 0, 8'h00, "start0");
    for (int i = 0; i < LEN; i++) cycle(0, 0, 0, 1, 8'(i + 1), "clamp0");
    check("clamp0.fill_const", 32'(fill_count), 32'd4);
    cycle(1, 7, 0, 0, 8'h00, "start7");
    for (int i = 0; i < LEN - 1; i++) cycle(0, 0, 0, 1, 8'(i + 8'h81), "clamp7");
    check("clamp7.not_full_yet", 32'(full), 32'd0);
    cycle(0, 0, 0, 1, 8'h84, "clamp7");
    check("clamp7.full_const", 32'(full), 32'd1);

    // Back-to-back restart from FULL.
    cycle(1, 2, 0, 0, 8'h00, "restart2");
    check("restart2.full_const", 32'(full), 32'd0);
    check("restart2.ready_const", 32'(ready), 32'd1);
    cycle(0, 0, 0, 1, 8'hAA, "restart2");
    cycle(0, 0, 0, 1, 8'hBB, "restart2");
    check("restart2.full_after", 32'(full), 32'd1);
    check("restart2.slot1_const", 32'(store[1]), 32'hBB);

    // Abort wins over a simultaneous start.
    cycle(1, 4, 0, 0, 8'h00, "abort");
    cycle(0, 0, 0, 1, 8'hC1, "abort");
    cycle(0, 0, 0, 1, 8'hC2, "abort");
    cycle(1, 4, 1, 0, 8'h00, "abort_start");
    check("abort.ready_const", 32'(ready), 32'd0);
    check("abort.fill_const", 32'(fill_count), 32'd0);
    check("abort.slot0_const", 32'(store[0]), 32'hC1);
    check("abort.slot1_const", 32'(store[1]), 32'hC2);
    cycle(0, 0, 0, 0, 8'h00, "abort_idle");

    // Asynchronous reset in the middle of a fill, checked before any edge.
    cycle(1, 4, 0, 0, 8'h00, "pre_rst");
    cycle(0, 0, 0, 1, 8'hD1, "pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.slot0_const", 32'(store[0]), 32'h00);
    #2 rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 5) == 0), $urandom_range(0, 7), ($urandom_range(0, 24) == 0),
            $urandom_range(0, 1) != 0, 8'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_collect.md
Name: serial_to_parallel_collect

Overview:
Collects a stream of N-bit words arriving one per handshake into a Length-deep parallel register array. It sits directly upstream of the parallel_to_serial stage and drives that stage's parallel store input. It holds the filled array stable until the consumer acknowledges it, so layer outputs can be regrouped into batches before being re-serialised.

Parameters:
N, 8, width of each data word
Length, 16, number of array slots (must be >= 1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
start_i  input  1  begin a collection; count_i sampled on the same edge
count_i  input  $clog2(Length+1)  number of words to collect
abort_i  input  1  synchronous abandon of the current collection
data_i  input  N  serial word in
valid_i  input  1  data_i valid
ready_o  output  1  block accepts a word this cycle
store_o  output  N x Length  unpacked array [Length-1:0]; slot 0 = first word received
fill_count_o  output  $clog2(Length+1)  words accepted in the current collection
full_o  output  1  array complete and stable
assert_on_i  input  1  enables internal simulation assertions

Behaviour:
- Reset (async, rst_i=1): state IDLE; ready_o=0; full_o=0; fill_count_o=0; every store_o slot = 0; latched target = 0.
- States: IDLE, FILL, FULL. Registered state; ready_o and full_o are decoded from state only, never from inputs.
- Target clamp: count_i==0 or count_i>Length latches the target as Length; otherwise it latches count_i.
- IDLE: ready_o=0. When start_i=1, the target is latched and fill_count_o is cleared to 0. The next state is FILL, so ready_o rises 1 cycle after start_i.
- FILL: ready_o=1. A word is accepted on any edge with valid_i&&ready_o. On acceptance:
  - data_i is written to store_o[fill_count_o].
  - fill_count_o increments.
  - If the accepted word makes fill_count_o equal to the target, the next state is FULL.
  - valid_i=0 stalls with no change. start_i in FILL is ignored.
- FULL: ready_o=0, full_o=1. store_o and fill_count_o are frozen.
  - start_i=1 latches a new target, clears fill_count_o, and goes to FILL (back-to-back batches). This start_i doubles as the consumer's load/acknowledge.
- abort_i (any state, checked before start_i): next state IDLE and fill_count_o=0; store_o contents are untouched. If abort_i and start_i arrive together, abort wins and start is dropped.
- Reset mid-operation returns immediately to the reset values, regardless of handshake.
- Slots at or above the target keep their previous contents unless the optional feature is enabled.
- Assertions (active when assert_on_i=1, simulation only):
  - fill_count_o never exceeds Length.
  - valid_i never goes X while ready_o=1.
  - No write ever occurs in IDLE or FULL.
- Latency: the last accepted word to full_o=1 is exactly 1 cycle. Maximum throughput is 1 word/cycle in FILL.

Optional Feature:
- Macro: SERIAL_TO_PARALLEL_COLLECT_ZERO_PAD_EN.
- Defined: on every accepted start_i, all Length slots of store_o are cleared to 0 on the same edge. Slots beyond the target therefore read 0 when full_o=1.
- Undefined: there is no clear on start. Unused slots retain stale data, and the store is cheaper (no wide clear mux).

Test Plan:
- Reset, Length=4, N=8: assert rst_i mid-FILL -> ready_o=0, full_o=0, fill_count_o=0, all store_o=0 in the same cycle, without waiting for a clock edge.
- start_i with count_i=4, then 4 back-to-back valid words 0x11,0x22,0x33,0x44 -> store_o[0..3]=0x11..0x44; full_o=1 on the cycle after 0x44; ready_o=0 during that cycle.
- count_i=3 with valid_i toggled 1,0,1,0,1 -> exactly 3 words accepted, fill_count_o=3, full_o=1; store_o[3] keeps its old value without ZERO_PAD_EN and reads 0 with it.
- count_i=0 and count_i=7 (Length=4) -> both collect 4 words before full_o=1.
- In FULL, pulse start_i with count_i=2 -> full_o falls and ready_o=1 next cycle; 0xAA,0xBB go into slots 0,1; full_o=1 after the 2nd word.
- In FILL after 2 words, assert abort_i and start_i together -> IDLE, fill_count_o=0, store_o[0..1] unchanged, ready_o=0 the next cycle.
